// File: rtl/mfp_sevenseg_pkg.sv
// Shared constants for the seven-segment display multiplexer.
// Glyph codes are 6 bits wide: [5] is the DP level (active-low) and [4:0] is the glyph index.
// Indices 0-15 are hex digits, 16-22 light a single segment a..g, 23-30 are special glyphs
// and 31 is blank.
package mfp_sevenseg_pkg;

  localparam logic [4:0] GLYPH_HEX_FIRST = 5'd0;
  localparam logic [4:0] GLYPH_HEX_LAST  = 5'd15;

  localparam logic [4:0] SEG_A = 5'd16;
  localparam logic [4:0] SEG_B = 5'd17;
  localparam logic [4:0] SEG_C = 5'd18;
  localparam logic [4:0] SEG_D = 5'd19;
  localparam logic [4:0] SEG_E = 5'd20;
  localparam logic [4:0] SEG_F = 5'd21;
  localparam logic [4:0] SEG_G = 5'd22;

  localparam logic [4:0] GLYPH_H   = 5'd23;
  localparam logic [4:0] GLYPH_L   = 5'd24;
  localparam logic [4:0] GLYPH_P   = 5'd25;
  localparam logic [4:0] GLYPH_U   = 5'd26;
  localparam logic [4:0] GLYPH_R   = 5'd27;
  localparam logic [4:0] GLYPH_O   = 5'd28;
  localparam logic [4:0] GLYPH_N   = 5'd29;
  localparam logic [4:0] GLYPH_DEG = 5'd30;

  localparam logic [4:0] GLYPH_BLANK = 5'd31;

  // DP off plus blank glyph: displays nothing.
  localparam logic [5:0] BLANK_CODE = 6'h3F;
  localparam logic [7:0] SEG_OFF    = 8'hFF;

endpackage

// File: rtl/mfp_sevenseg_glyph.sv
// Combinational glyph lookup for a single seven-segment digit.
// Ports:
//   code - 6-bit glyph code: [5] DP level (active-low), [4:0] glyph index
//   seg  - active-low cathodes {DP, a, b, c, d, e, f, g}
module mfp_sevenseg_glyph
  import mfp_sevenseg_pkg::*;
(
  input  logic [5:0] code,
  output logic [7:0] seg
);

  // Bit 6 is segment a, bit 0 is segment g; a 0 lights the segment.
  logic [6:0] segs;

  always_comb begin
    segs = 7'h7F;
    case (code[4:0])
      GLYPH_HEX_FIRST: segs = 7'h01;
      5'd1:            segs = 7'h4F;
      5'd2:            segs = 7'h12;
      5'd3:            segs = 7'h06;
      5'd4:            segs = 7'h4C;
      5'd5:            segs = 7'h24;
      5'd6:            segs = 7'h20;
      5'd7:            segs = 7'h0F;
      5'd8:            segs = 7'h00;
      5'd9:            segs = 7'h04;
      5'd10:           segs = 7'h08;
      5'd11:           segs = 7'h60;
      5'd12:           segs = 7'h31;
      5'd13:           segs = 7'h42;
      5'd14:           segs = 7'h30;
      GLYPH_HEX_LAST:  segs = 7'h38;
      SEG_A:           segs = 7'h3F;
      SEG_B:           segs = 7'h5F;
      SEG_C:           segs = 7'h6F;
      SEG_D:           segs = 7'h77;
      SEG_E:           segs = 7'h7B;
      SEG_F:           segs = 7'h7D;
      SEG_G:           segs = 7'h7E;
      GLYPH_H:         segs = 7'h48;
      GLYPH_L:         segs = 7'h71;
      GLYPH_P:         segs = 7'h18;
      GLYPH_U:         segs = 7'h41;
      GLYPH_R:         segs = 7'h7A;
      GLYPH_O:         segs = 7'h62;
      GLYPH_N:         segs = 7'h6A;
      GLYPH_DEG:       segs = 7'h1C;
      GLYPH_BLANK:     segs = 7'h7F;
      default:         segs = 7'h7F;
    endcase
  end

  assign seg = {code[5], segs};

endmodule

// File: rtl/mfp_ahb_sevensegmux.sv
// Time-multiplexed seven-segment display driver with frame-synchronous double buffering.
// A prescaler divides HCLK into digit slots; each slot starts with a short all-anodes-off
// window to suppress ghosting. New digit data is captured into a pending buffer on load and
// only copied to the displayed buffer at a frame boundary, so a frame never tears.
// Optional feature: define SEVENSEG_BLINK_EN to enable per-digit blinking with a half-period
// of BLINK_FRAMES frames; without it blink_in has no effect.
// Ports:
//   HCLK, HRESET - clock and asynchronous active-high reset
//   digits_in    - packed 6-bit glyph codes, digit i at [6i+5:6i]
//   en_in        - per-digit enable
//   blink_in     - per-digit blink select
//   load         - capture digits_in/en_in/blink_in into the pending buffer
//   busy         - pending data waiting for the next frame boundary
//   frame_start  - one-cycle pulse as slot 0 begins
//   an           - active-low anodes (registered)
//   seg          - active-low cathodes {DP, a..g} (registered)
module mfp_ahb_sevensegmux
  import mfp_sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 20000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [6*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    load,
  output logic                    busy,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]    BLANK_LOAD = 8'(BLANK_CYCLES);

  logic [PW-1:0] pre_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    blank_q;
  logic          busy_q;
  logic          tick;
  logic          boundary;
  logic          phase;

  logic [6*NUM_DIGITS-1:0] pend_digits_q, act_digits_q;
  logic [NUM_DIGITS-1:0]   pend_en_q, act_en_q;
  logic [NUM_DIGITS-1:0]   pend_blink_q, act_blink_q;

  assign tick     = (pre_q == PRE_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);

  // Slot timing: prescaler, digit index and anti-ghosting blank counter.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pre_q       <= '0;
      idx_q       <= '0;
      blank_q     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (tick) begin
        pre_q   <= '0;
        idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        blank_q <= BLANK_LOAD;
      end else begin
        pre_q <= pre_q + PW'(1);
        if (blank_q != '0) blank_q <= blank_q - 8'd1;
      end
    end
  end

  // Double buffer. Nonblocking reads mean a load on the boundary cycle still moves the
  // previous pending data to active while capturing the new data.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pend_digits_q <= {NUM_DIGITS{BLANK_CODE}};
      act_digits_q  <= {NUM_DIGITS{BLANK_CODE}};
      pend_en_q     <= '0;
      act_en_q      <= '0;
      pend_blink_q  <= '0;
      act_blink_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      if (boundary && busy_q) begin
        act_digits_q <= pend_digits_q;
        act_en_q     <= pend_en_q;
        act_blink_q  <= pend_blink_q;
      end
      if (load) begin
        pend_digits_q <= digits_in;
        pend_en_q     <= en_in;
        pend_blink_q  <= blink_in;
      end
      busy_q <= load | (busy_q & ~boundary);
    end
  end

  assign busy = busy_q;

`ifdef SEVENSEG_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt_q;
  logic          phase_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (boundary) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + FW'(1);
      end
    end
  end

  assign phase = phase_q;
`else
  assign phase = 1'b0;
`endif

  // Select the currently scanned digit.
  logic [5:0] cur_code;
  logic       cur_en;
  logic       cur_blink;

  always_comb begin
    cur_code  = BLANK_CODE;
    cur_en    = 1'b0;
    cur_blink = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_code  = act_digits_q[6*i +: 6];
        cur_en    = act_en_q[i];
        cur_blink = act_blink_q[i];
      end
    end
  end

  logic [7:0] glyph_seg;

  mfp_sevenseg_glyph u_glyph (
    .code (cur_code),
    .seg  (glyph_seg)
  );

  logic                  show;
  logic [NUM_DIGITS-1:0] an_d;
  logic [7:0]            seg_d;

  always_comb begin
    show  = (blank_q == '0) && cur_en && !(cur_blink && phase);
    an_d  = '1;
    seg_d = SEG_OFF;
    if (show) begin
      an_d[idx_q] = 1'b0;
      seg_d       = glyph_seg;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      an  <= '1;
      seg <= SEG_OFF;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_mfp_ahb_sevensegmux.sv
// Scoreboard bench for mfp_ahb_sevensegmux (4 digits, 8 clocks per slot, 2 blank cycles).
// The reference model derives slot, position and frame purely from the number of clock
// edges since reset release; a monitor compares every cycle on the falling edge.
module tb_mfp_ahb_sevensegmux;

  localparam int unsigned N  = 4;
  localparam int unsigned R  = 8;
  localparam int unsigned B  = 2;
  localparam int unsigned BF = 2;
  localparam int unsigned FR = N * R;

  logic             HCLK = 1'b0;
  logic             HRESET = 1'b1;
  logic [6*N-1:0]   digits_in = '0;
  logic [N-1:0]     en_in = '0;
  logic [N-1:0]     blink_in = '0;
  logic             load = 1'b0;
  logic             busy;
  logic             frame_start;
  logic [N-1:0]     an;
  logic [7:0]       seg;

  always #5 HCLK = ~HCLK;

  mfp_ahb_sevensegmux #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B),
    .BLINK_FRAMES (BF)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .digits_in   (digits_in),
    .en_in       (en_in),
    .blink_in    (blink_in),
    .load        (load),
    .busy        (busy),
    .frame_start (frame_start),
    .an          (an),
    .seg         (seg)
  );

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [N-1:0] an;
    logic [7:0]   seg;
    logic         busy;
    logic         fs;
  } exp_t;

  exp_t expq[$];

  // Active-low {a..g} patterns by glyph index.
  logic [6:0] glyph_ref [32] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38,
    7'h3F, 7'h5F, 7'h6F, 7'h77, 7'h7B, 7'h7D, 7'h7E,
    7'h48, 7'h71, 7'h18, 7'h41, 7'h7A, 7'h62, 7'h6A, 7'h1C,
    7'h7F
  };

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model state.
  int unsigned    m;
  logic [6*N-1:0] act_d, pen_d;
  logic [N-1:0]   act_en, pen_en, act_bl, pen_bl;
  bit             busy_m;

  task automatic model_step();
    int unsigned idx;
    int unsigned pos;
    bit          blanking;
    bit          phase;
    bit          show;
    logic [5:0]  code;
    exp_t        e;
    if (HRESET) begin
      m      = 0;
      act_d  = {N{6'h3F}};
      pen_d  = {N{6'h3F}};
      act_en = '0;
      pen_en = '0;
      act_bl = '0;
      pen_bl = '0;
      busy_m = 1'b0;
      return;
    end
    idx      = (m / R) % N;
    pos      = m % R;
    blanking = (m >= R) && (pos < B);
`ifdef SEVENSEG_BLINK_EN
    phase = (((m / FR) / BF) % 2) == 1;
`else
    phase = 1'b0;
`endif
    code  = act_d[6*idx +: 6];
    show  = !blanking && act_en[idx] && !(act_bl[idx] && phase);
    e.an  = '1;
    e.seg = 8'hFF;
    if (show) begin
      e.an[idx] = 1'b0;
      e.seg     = {code[5], glyph_ref[code[4:0]]};
    end
    m++;
    e.fs = (m % FR) == 0;
    if (e.fs && busy_m) begin
      act_d  = pen_d;
      act_en = pen_en;
      act_bl = pen_bl;
      busy_m = 1'b0;
    end
    if (load) begin
      pen_d  = digits_in;
      pen_en = en_in;
      pen_bl = blink_in;
      busy_m = 1'b1;
    end
    e.busy = busy_m;
    expq.push_back(e);
  endtask

  initial forever begin
    @(posedge HCLK);
    model_step();
  end

  // Monitor: the DUT presents outputs every cycle.
  initial forever begin
    exp_t e;
    @(negedge HCLK);
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("an", an, e.an);
      check("seg", seg, e.seg);
      check("busy", busy, e.busy);
      check("frame_start", frame_start, e.fs);
    end
  end

  task automatic do_load(logic [6*N-1:0] d, logic [N-1:0] e, logic [N-1:0] b);
    digits_in = d;
    en_in     = e;
    blink_in  = b;
    load      = 1'b1;
    @(negedge HCLK);
    load = 1'b0;
  endtask

  // Advance on falling edges until the edge count modulo one frame equals target.
  task automatic wait_mod(int unsigned target);
    for (int i = 0; i < 4 * FR; i++) begin
      if ((m % FR) == target) return;
      @(negedge HCLK);
    end
    total++;
    bad++;
    $display("FAIL wait_mod: position %0d never reached (got %0d)", target, m % FR);
  endtask

  task automatic idle_checks(string name);
    check({name, "_an"}, an, 4'hF);
    check({name, "_seg"}, seg, 8'hFF);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_fs"}, frame_start, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge HCLK);
    idle_checks("reset");
    HRESET = 1'b0;

    // Idle display after reset.
    repeat (100) @(negedge HCLK);

    // Digits 3..0 = 21, 02, 23, 01, all enabled.
    do_load({6'h21, 6'h02, 6'h23, 6'h01}, 4'hF, 4'h0);
    check("busy_after_load", busy, 1'b1);
    wait_mod(0);
    wait_mod(2);
    check("slot0_blank_an", an, 4'hF);
    wait_mod(3);
    check("slot0_an", an, 4'b1110);
    check("slot0_seg", seg, 8'h4F);
    wait_mod(11);
    check("slot1_an", an, 4'b1101);
    check("slot1_seg", seg, 8'h86);
    wait_mod(19);
    check("slot2_an", an, 4'b1011);
    check("slot2_seg", seg, 8'h12);

    // Only digits 0 and 2 enabled.
    do_load({6'h21, 6'h02, 6'h23, 6'h01}, 4'b0101, 4'h0);
    wait_mod(0);
    wait_mod(11);
    check("en_slot1_an", an, 4'hF);
    check("en_slot1_seg", seg, 8'hFF);

    // Prior pending data, then a load exactly on the boundary cycle.
    wait_mod(20);
    do_load({6'h0A, 6'h0B, 6'h0C, 6'h0D}, 4'hF, 4'h0);
    wait_mod(FR - 1);
    do_load({6'h1F, 6'h04, 6'h05, 6'h06}, 4'hF, 4'b0010);
    check("busy_after_boundary_load", busy, 1'b1);
    repeat (2 * FR) @(negedge HCLK);

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(1, 50)) @(negedge HCLK);
      do_load({$urandom, $urandom} [6*N-1:0], 4'($urandom), 4'($urandom));
    end
    repeat (3 * FR) @(negedge HCLK);

    // Reset during blanking of slot 2 with a pending update.
    wait_mod(R);
    do_load({6'h08, 6'h08, 6'h08, 6'h08}, 4'hF, 4'h0);
    wait_mod(2 * R + 1);
    check("busy_before_reset", busy, 1'b1);
    #2;
    HRESET = 1'b1;
    #1;
    idle_checks("mid_reset");
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    repeat (3 * FR) @(negedge HCLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
